// File: rtl/top_dff_en_pkg.sv
// Shared constants for the clock-enabled register block.
package top_dff_en_pkg;

    // Default geometry: a single 1-bit enabled flip-flop.
    localparam int unsigned DFF_EN_WIDTH_DEF  = 1;
    localparam int unsigned DFF_EN_STAGES_DEF = 1;

    // Number of chain taps for a given depth: the input tap plus one per stage.
    function automatic int unsigned dff_en_taps(input int unsigned stages);
        return stages + 1;
    endfunction

endpackage

// File: rtl/top_dff_en_if.sv
// Load/data bus of the enabled register: en and d in, q out.
interface top_dff_en_if #(
    parameter int unsigned WIDTH = 1
) ();

    logic             en;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    // Producer side: drives load enable and data, observes q.
    modport master (
        output en,
        output d,
        input  q
    );

    // Register side: samples en and d, drives q.
    modport slave (
        input  en,
        input  d,
        output q
    );

endinterface

// File: rtl/top_dff_en_stage.sv
// One WIDTH-wide enabled register with asynchronous active-high reset.
module top_dff_en_stage #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next value: load d when enabled, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    // State register; reset wins over clock and enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/top_dff_en.sv
// Clock-enabled D register pipeline: STAGES enabled stages from d to q,
// all shifting together under one enable.
module top_dff_en
    import top_dff_en_pkg::*;
#(
    parameter int unsigned      WIDTH       = DFF_EN_WIDTH_DEF,
    parameter int unsigned      STAGES      = DFF_EN_STAGES_DEF,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         rst,
    top_dff_en_if.slave  bus
);

    localparam int unsigned TAPS = dff_en_taps(STAGES);

    // chain[0] is the input; chain[i] is the output of stage i-1.
    logic [WIDTH-1:0] chain [TAPS];

    assign chain[0] = bus.d;

    // Stage array; every stage shares the single load enable.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        top_dff_en_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .en  (bus.en),
            .d   (chain[i]),
            .q   (chain[i+1])
        );
    end

    assign bus.q = chain[STAGES];

endmodule

// File: tb/tb_top_dff_en.sv
// Self-checking bench: default 1-bit/1-stage instance and an 8-bit/3-stage
// instance, directed scenarios followed by randomized traffic against a
// queue-based reference model.
module tb_top_dff_en;

    localparam int unsigned WB = 8;
    localparam int unsigned SB = 3;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    top_dff_en_if #(.WIDTH(1))  bus_a ();
    top_dff_en_if #(.WIDTH(WB)) bus_b ();

    top_dff_en #(
        .WIDTH       (1),
        .STAGES      (1),
        .RESET_VALUE (1'b0)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    top_dff_en #(
        .WIDTH       (WB),
        .STAGES      (SB),
        .RESET_VALUE (8'h00)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Reference model: each pipeline is a FIFO of in-flight words, newest at
    // the front, q is the oldest. An enabled edge admits d and retires one.
    logic          mq_a [$];
    logic [WB-1:0] mq_b [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq_a = {};
            mq_b = {};
            mq_a.push_back(1'b0);
            for (int k = 0; k < int'(SB); k++) mq_b.push_back(8'h00);
        end else begin
            if (bus_a.en === 1'b1) begin
                mq_a.push_front(bus_a.d);
                void'(mq_a.pop_back());
            end
            if (bus_b.en === 1'b1) begin
                mq_b.push_front(bus_b.d);
                void'(mq_b.pop_back());
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_a"}, 32'(bus_a.q), 32'(mq_a[$]));
        check({tag, "_b"}, 32'(bus_b.q), 32'(mq_b[$]));
    endtask

    initial begin
        rst      = 1'b1;
        bus_a.en = 1'b0;
        bus_a.d  = 1'b0;
        bus_b.en = 1'b0;
        bus_b.d  = 8'h00;
        tick();
        tick();
        check("reset_a", 32'(bus_a.q), 32'h0);
        check("reset_b", 32'(bus_b.q), 32'h0);
        rst = 1'b0;

        // Enable low: d toggles but q holds reset value.
        tick();
        bus_a.d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("en_low_hold", 32'(bus_a.q), 32'h0);
        end
        check_model("en_low_model");

        // Enable and data change together.
        bus_a.en = 1'b1;
        bus_a.d  = 1'b0;
        tick();
        check("en_d_together", 32'(bus_a.q), 32'h0);
        bus_a.d = 1'b1;
        tick();
        check("load_one", 32'(bus_a.q), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("load_one_held", 32'(bus_a.q), 32'h1);
        end

        // Async reset between edges, held across enabled edges.
        #2 rst = 1'b1;
        #1 check("async_reset_immediate", 32'(bus_a.q), 32'h0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_held", 32'(bus_a.q), 32'h0);
        end
        rst = 1'b0;
        tick();
        check("reset_release_load", 32'(bus_a.q), 32'h1);

        // Hold under enable drop, then re-enable.
        bus_a.en = 1'b0;
        bus_a.d  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("en_drop_hold", 32'(bus_a.q), 32'h1);
        end
        bus_a.en = 1'b1;
        tick();
        check("reenable_load", 32'(bus_a.q), 32'h0);

        // 8-bit, 3-stage latency and stall.
        bus_b.en = 1'b1;
        bus_b.d  = 8'hA5;
        tick();
        bus_b.d = 8'h3C;
        tick();
        bus_b.d = 8'h11;
        tick();
        check("pipe_lat3", 32'(bus_b.q), 32'hA5);
        bus_b.d = 8'h22;
        tick();
        check("pipe_lat4", 32'(bus_b.q), 32'h3C);
        bus_b.en = 1'b0;
        bus_b.d  = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("pipe_stall", 32'(bus_b.q), 32'h3C);
        end
        bus_b.en = 1'b1;
        bus_b.d  = 8'h33;
        tick();
        check("pipe_resume", 32'(bus_b.q), 32'h11);
        tick();
        check("pipe_resume2", 32'(bus_b.q), 32'h22);
        check_model("directed_end");

        // Randomized traffic with occasional async reset pulses.
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 39) == 0);
            bus_a.en = ($urandom_range(0, 3) != 0);
            bus_a.d  = 1'($urandom());
            bus_b.en = ($urandom_range(0, 3) != 0);
            bus_b.d  = 8'($urandom());
            if (rst) begin
                #1 check_model("rand_async_reset");
                @(negedge clk);
            end
            tick();
            check_model("rand");
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
